// File: rtl/alu_muldiv_if.sv
// Request/result bundle between the EX stage and the iterative multiply/divide unit.
interface alu_muldiv_if #(
    parameter int N = 31
);
    logic       start;
    logic [5:0] op;
    logic [N:0] a;
    logic [N:0] b;
    logic       busy;
    logic       done;
    logic [N:0] hi;
    logic [N:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/alu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; MTHI/MTLO complete in one cycle.
// Define MDU_MADD_EN to add MADD/MADDU (accumulate the product into {hi,lo}).
module alu_muldiv #(
    parameter int N     = 31,
    parameter int CNT_W = $clog2(N + 1) + 1
) (
    input  logic        clk,
    input  logic        reset,
    alu_muldiv_if.slave bus
);
    localparam int W = N + 1;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;
`ifdef MDU_MADD_EN
    localparam logic [5:0] OP_MADD  = 6'b011100;
    localparam logic [5:0] OP_MADDU = 6'b011101;
`endif

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [2*W-1:0]   acc_reg;
    logic [N:0]       opnd_reg;
    logic [N:0]       a_reg;
    logic             bzero_reg, is_div_reg, is_madd_reg, neg_res_reg, neg_rem_reg;
    logic             done_reg;
    logic [N:0]       hi_reg, lo_reg;

    logic             op_mul, op_div, op_signed, op_madd, accept;
    logic [N:0]       mag_a, mag_b;
    logic [W:0]       add_sum, shifted, diff;
    logic [2*W-1:0]   iter, prod_fixed, fix_val;
    logic [N:0]       quo, rem;

    always_comb begin
        op_mul    = 1'b0;
        op_div    = 1'b0;
        op_signed = 1'b0;
        op_madd   = 1'b0;
        case (bus.op)
            OP_MULT:  begin op_mul = 1'b1; op_signed = 1'b1; end
            OP_MULTU: op_mul = 1'b1;
            OP_DIV:   begin op_div = 1'b1; op_signed = 1'b1; end
            OP_DIVU:  op_div = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD:  begin op_mul = 1'b1; op_signed = 1'b1; op_madd = 1'b1; end
            OP_MADDU: begin op_mul = 1'b1; op_madd = 1'b1; end
`endif
            default:  ;
        endcase
    end

    assign accept = bus.start && (state_reg == IDLE);
    assign mag_a  = (op_signed && bus.a[N]) ? -bus.a : bus.a;
    assign mag_b  = (op_signed && bus.b[N]) ? -bus.b : bus.b;

    // Multiply keeps the partial product in the top half and the multiplier in the
    // bottom; divide keeps the partial remainder on top and the dividend/quotient below.
    always_comb begin
        add_sum = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, opnd_reg} : {(W+1){1'b0}});
        shifted = {acc_reg[2*W-1:W], acc_reg[W-1]};
        diff    = shifted - {1'b0, opnd_reg};
        if (is_div_reg) begin
            if (shifted >= {1'b0, opnd_reg})
                iter = {diff[W-1:0], acc_reg[W-2:0], 1'b1};
            else
                iter = {shifted[W-1:0], acc_reg[W-2:0], 1'b0};
        end else begin
            iter = {add_sum, acc_reg[W-1:1]};
        end
    end

    always_comb begin
        prod_fixed = neg_res_reg ? ('0 - acc_reg) : acc_reg;
        quo        = acc_reg[W-1:0];
        rem        = acc_reg[2*W-1:W];
        if (is_div_reg) begin
            if (bzero_reg)
                fix_val = {a_reg, {W{1'b1}}};
            else
                fix_val = {(neg_rem_reg ? -rem : rem), (neg_res_reg ? -quo : quo)};
        end else if (is_madd_reg) begin
            fix_val = {hi_reg, lo_reg} + prod_fixed;
        end else begin
            fix_val = prod_fixed;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept && (op_mul || op_div)) state_next = CALC;
            CALC:    if (cnt_reg == CNT_W'(N)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            opnd_reg    <= '0;
            a_reg       <= '0;
            bzero_reg   <= 1'b0;
            is_div_reg  <= 1'b0;
            is_madd_reg <= 1'b0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            done_reg    <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == FIX);
            case (state_reg)
                IDLE: begin
                    if (accept && (op_mul || op_div)) begin
                        cnt_reg     <= '0;
                        acc_reg     <= {{W{1'b0}}, (op_div ? mag_a : mag_b)};
                        opnd_reg    <= op_div ? mag_b : mag_a;
                        a_reg       <= bus.a;
                        bzero_reg   <= (bus.b == '0);
                        is_div_reg  <= op_div;
                        is_madd_reg <= op_madd;
                        neg_res_reg <= op_signed && (bus.a[N] ^ bus.b[N]);
                        neg_rem_reg <= op_signed && bus.a[N];
                    end else if (accept && (bus.op == OP_MTHI)) begin
                        hi_reg <= bus.a;
                    end else if (accept && (bus.op == OP_MTLO)) begin
                        lo_reg <= bus.a;
                    end
                end
                CALC: begin
                    acc_reg <= iter;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
                FIX:     {hi_reg, lo_reg} <= fix_val;
                default: ;
            endcase
        end
    end

    assign bus.busy = (state_reg != IDLE);
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: arithmetic reference model checked every cycle, plus literal results.
module tb_alu_muldiv;
    localparam int N = 31;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;
    localparam logic [5:0] OP_MADD  = 6'b011100;
    localparam logic [5:0] OP_MADDU = 6'b011101;
    localparam logic [5:0] OP_BAD   = 6'b000000;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic checking = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    alu_muldiv_if #(.N(N)) bus ();
    alu_muldiv #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic is_long(input logic [5:0] op);
        logic r;
        r = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
        r = r || (op == OP_MADD) || (op == OP_MADDU);
`endif
        return r;
    endfunction

    // Reference result {hi,lo} using plain 64-bit arithmetic.
    function automatic logic [63:0] model_result(input logic [5:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [63:0] hilo);
        longint      sa, sb, q, rm;
        logic [63:0] ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        r  = '0;
        case (op)
            OP_MULT:  r = sa * sb;
            OP_MULTU: r = ua * ub;
            OP_MADD:  r = hilo + 64'(sa * sb);
            OP_MADDU: r = hilo + ua * ub;
            OP_DIV, OP_DIVU: begin
                if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
                else if (op == OP_DIV) begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {rm[31:0], q[31:0]};
                end else begin
                    r = {32'(ua % ub), 32'(ua / ub)};
                end
            end
            default: r = hilo;
        endcase
        return r;
    endfunction

    logic [31:0] m_hi, m_lo;
    logic        m_done;
    int          m_left;
    logic [63:0] m_res;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_left <= 0; m_res <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    {m_hi, m_lo} <= m_res;
                    m_done <= 1'b1;
                end
            end else if (bus.start) begin
                if (is_long(bus.op)) begin
                    m_res  <= model_result(bus.op, bus.a, bus.b, {m_hi, m_lo});
                    m_left <= N + 2;
                end else if (bus.op == OP_MTHI) m_hi <= bus.a;
                else if (bus.op == OP_MTLO) m_lo <= bus.a;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("busy", 64'(bus.busy), 64'(m_left != 0));
            check("done", 64'(bus.done), 64'(m_done));
            check("hi",   64'(bus.hi),   64'(m_hi));
            check("lo",   64'(bus.lo),   64'(m_lo));
        end
    end

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles = 0;
        busy_cycles = 0;
        while (bus.done !== 1'b1 && cycles < 100) begin
            if (bus.busy === 1'b1) busy_cycles++;
            @(negedge clk);
            cycles++;
        end
        check("done_seen", 64'(bus.done), 64'(1));
    endtask

    task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc, bcyc;
        issue(op, a, b);
        wait_done(cyc, bcyc);
        check({name, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check({name, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        check({name, "_busy_cycles"}, 64'(bcyc), 64'(N + 2));
        $display("%s op=%b a=%h b=%h -> hi=%h lo=%h after %0d cycles", name, op, a, b, bus.hi, bus.lo, cyc);
    endtask

    initial begin
        int cyc, bcyc, done_cnt;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        #1 reset = 1'b1;
        checking = 1'b1;
        #2;
        check("reset_busy", 64'(bus.busy), 64'(0));
        check("reset_hi",   64'(bus.hi),   64'(0));
        check("reset_lo",   64'(bus.lo),   64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("mult_min",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero", OP_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
        run_op("div_wrap",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("divu_100",  OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);

        issue(OP_MTHI, 32'h0000_1234, 32'h0);
        check("mthi_hi",   64'(bus.hi),   64'(32'h0000_1234));
        check("mthi_busy", 64'(bus.busy), 64'(0));
        check("mthi_done", 64'(bus.done), 64'(0));
        $display("mthi a=00001234 -> hi=%h", bus.hi);
        issue(OP_MTLO, 32'h0000_5678, 32'h0);
        check("mtlo_lo", 64'(bus.lo), 64'(32'h0000_5678));
        $display("mtlo a=00005678 -> lo=%h", bus.lo);
        issue(OP_BAD, 32'hDEAD_BEEF, 32'h1);
        check("bad_busy", 64'(bus.busy), 64'(0));
        check("bad_hi",   64'(bus.hi),   64'(32'h0000_1234));
        check("bad_lo",   64'(bus.lo),   64'(32'h0000_5678));
        $display("unlisted op -> hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);

        // A second start while busy must not disturb the divide in flight.
        issue(OP_DIV, 32'hFFFF_FF9C, 32'd7);
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd3; bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(cyc, bcyc);
        check("overlap_hi", 64'(bus.hi), 64'(32'hFFFF_FFFE));
        check("overlap_lo", 64'(bus.lo), 64'(32'hFFFF_FFF2));
        done_cnt = 1;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
        end
        check("overlap_done_pulses", 64'(done_cnt), 64'(1));
        $display("div -100/7 with mult during busy -> hi=%h lo=%h done pulses=%0d", bus.hi, bus.lo, done_cnt);

        issue(OP_MULTU, 32'd5, 32'd7);
        repeat (8) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("async_rst_busy", 64'(bus.busy), 64'(0));
        check("async_rst_done", 64'(bus.done), 64'(0));
        check("async_rst_hi",   64'(bus.hi),   64'(0));
        check("async_rst_lo",   64'(bus.lo),   64'(0));
        $display("reset mid multu -> busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
        @(negedge clk);
        reset = 1'b0;
        run_op("multu_after_rst", OP_MULTU, 32'd5, 32'd7, 32'd0, 32'd35);

        issue(OP_MTLO, 32'd10, 32'h0);
        issue(OP_MTHI, 32'd0, 32'h0);
`ifdef MDU_MADD_EN
        run_op("madd", OP_MADD, 32'd2, 32'd3, 32'd0, 32'd16);
        issue(OP_MTLO, 32'hFFFF_FFFF, 32'h0);
        run_op("maddu_carry", OP_MADDU, 32'd1, 32'd1, 32'd1, 32'd0);
`else
        issue(OP_MADD, 32'd2, 32'd3);
        check("madd_off_busy", 64'(bus.busy), 64'(0));
        check("madd_off_hi",   64'(bus.hi),   64'(0));
        check("madd_off_lo",   64'(bus.lo),   64'(32'd10));
        $display("madd without feature -> busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
`endif
        run_op("multu_mix", OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 32'h242D_2080);

        repeat (2) @(negedge clk);
        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
